// File: rtl/preadd_pkg.sv
// Shared constants and encodings for the pre-adder result unpacker.
package preadd_pkg;
    localparam int SEG_W      = 19;
    localparam int CHAIN_HI_W = 9;

    typedef enum logic {
        MODE_DUAL  = 1'b0,
        MODE_CHAIN = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_e;
endpackage

// File: rtl/preadd_lane_ext.sv
// Widens one dual-mode pre-adder segment to the output width, zero- or sign-extended.
module preadd_lane_ext
    import preadd_pkg::*;
#(
    parameter int SEG_W    = 19,
    parameter int OUT_W    = 28,
    parameter int SIGN_EXT = 0
) (
    input  logic [SEG_W-1:0] i_seg,
    output logic [OUT_W-1:0] o_ext
);
    generate
        if (SIGN_EXT != 0) begin : g_sext
            assign o_ext = OUT_W'($signed(i_seg));
        end else begin : g_zext
            assign o_ext = OUT_W'(i_seg);
        end
    endgenerate
endmodule

// File: rtl/preadd_result_unpacker.sv
// Splits a packed pre-adder result word into one (chained) or two (dual) output beats
// behind a one-entry holding register, with valid/ready on both sides.
module preadd_result_unpacker
    import preadd_pkg::*;
#(
    parameter int SEG_W    = 19,
    parameter int OUT_W    = 28,
    parameter int SIGN_EXT = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*SEG_W-1:0] in_data,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_lane,
    output logic               out_last,
    output logic [CNT_W-1:0]   result_count,
    output logic               fmt_err
);
    state_e             r_state;
    state_e             w_state_nxt;
    logic [2*SEG_W-1:0] r_data;
    mode_e              r_mode;
    logic [CNT_W-1:0]   r_count;
    logic               r_fmt_err;

    logic               w_last;
    logic               w_accept;
    logic               w_handoff;
    logic               w_fmt_bad;
    logic [OUT_W-1:0]   w_ext_lo;
    logic [OUT_W-1:0]   w_ext_hi;
    logic [OUT_W-1:0]   w_chain;

    preadd_lane_ext #(.SEG_W(SEG_W), .OUT_W(OUT_W), .SIGN_EXT(SIGN_EXT)) u_ext_lo (
        .i_seg (r_data[SEG_W-1:0]),
        .o_ext (w_ext_lo)
    );

    preadd_lane_ext #(.SEG_W(SEG_W), .OUT_W(OUT_W), .SIGN_EXT(SIGN_EXT)) u_ext_hi (
        .i_seg (r_data[2*SEG_W-1:SEG_W]),
        .o_ext (w_ext_hi)
    );

    // Chained sum: seg_hi's low bits sit directly above seg_lo, carry-out included.
    assign w_chain   = OUT_W'(r_data[SEG_W+CHAIN_HI_W-1:0]);
    assign w_fmt_bad = in_mode && (in_data[2*SEG_W-1:SEG_W+CHAIN_HI_W] != '0);

    assign w_last    = (r_state == BEAT1) || ((r_state == BEAT0) && (r_mode == MODE_CHAIN));
    assign in_ready  = (r_state == EMPTY) || (w_last && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_handoff = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_accept) w_state_nxt = BEAT0;
            BEAT0: begin
                if (out_ready) begin
                    if (r_mode == MODE_CHAIN) w_state_nxt = w_accept ? BEAT0 : EMPTY;
                    else                      w_state_nxt = BEAT1;
                end
            end
            BEAT1: if (out_ready) w_state_nxt = w_accept ? BEAT0 : EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_data = '0;
        case (r_state)
            BEAT0:   out_data = (r_mode == MODE_CHAIN) ? w_chain : w_ext_lo;
            BEAT1:   out_data = w_ext_hi;
            default: out_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= '0;
            r_mode    <= MODE_DUAL;
            r_count   <= '0;
            r_fmt_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data <= in_data;
                r_mode <= mode_e'(in_mode);
            end
            if (w_accept && w_fmt_bad) r_fmt_err <= 1'b1;
            if (w_handoff)             r_count   <= r_count + 1'b1;
        end
    end

    assign out_valid    = (r_state != EMPTY);
    assign out_lane     = (r_state == BEAT1);
    assign out_last     = w_last;
    assign result_count = r_count;
    assign fmt_err      = r_fmt_err;
endmodule

// File: tb/tb_preadd_result_unpacker.sv
// Scoreboard bench: zero- and sign-extending unpackers share one stimulus stream.
module tb_preadd_result_unpacker;
    typedef struct packed {
        logic [27:0] data;
        logic        lane;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [37:0] in_data = '0;
    logic        in_mode = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready [2];
    logic        out_valid[2];
    logic [27:0] out_data [2];
    logic        out_lane [2];
    logic        out_last [2];
    logic [15:0] res_cnt  [2];
    logic        fmt_err  [2];

    int n_chk  = 0;
    int n_pass = 0;
    int rdy_mode = 1;   // 0 random, 1 held high, 2 held low

    beat_t q[2][$];
    int    cnt_m = 0;
    bit    fmt_m = 0;

    always #5 clk = ~clk;

    preadd_result_unpacker #(.SEG_W(19), .OUT_W(28), .SIGN_EXT(0), .CNT_W(16)) u_dut_z (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .out_lane(out_lane[0]), .out_last(out_last[0]),
        .result_count(res_cnt[0]), .fmt_err(fmt_err[0])
    );

    preadd_result_unpacker #(.SEG_W(19), .OUT_W(28), .SIGN_EXT(1), .CNT_W(16)) u_dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .out_lane(out_lane[1]), .out_last(out_last[1]),
        .result_count(res_cnt[1]), .fmt_err(fmt_err[1])
    );

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    endtask

    // Reference: a segment value as an integer, optionally reinterpreted as 19-bit signed.
    function automatic logic [27:0] ext19(input longint v, input bit sx);
        longint t = v;
        if (sx && t >= 262144) t = t - 524288;
        return 28'(t);
    endfunction

    // Monitor / scoreboard, sampled one time unit before each rising edge.
    always @(negedge clk) begin
        #4;
        if (reset) begin
            for (int d = 0; d < 2; d++) q[d].delete();
            cnt_m = 0;
            fmt_m = 0;
        end else begin
            bit acc;
            acc = in_valid && ((q[0].size() == 0) || (q[0].size() == 1 && out_ready));
            for (int d = 0; d < 2; d++) begin
                bit exp_rdy;
                exp_rdy = (q[d].size() == 0) || (q[d].size() == 1 && out_ready);
                chk("in_ready", d, 64'(in_ready[d]), 64'(exp_rdy));
                chk("out_valid", d, 64'(out_valid[d]), 64'(q[d].size() != 0));
                chk("result_count", d, 64'(res_cnt[d]), 64'(cnt_m % 65536));
                chk("fmt_err", d, 64'(fmt_err[d]), 64'(fmt_m));
                if (q[d].size() != 0) begin
                    chk("beat", d, 64'({out_data[d], out_lane[d], out_last[d]}), 64'(q[d][0]));
                    if (out_ready) void'(q[d].pop_front());
                end
            end
            if (q[0].size() == 0 && q[1].size() == 0 && out_ready && out_valid[0]) begin
                // nothing expected; already flagged via out_valid check
            end
            if (out_ready && (acc ? 1'b1 : 1'b1) && (cnt_pending())) cnt_m++;
            if (acc) begin
                longint w, lo, hi;
                w  = longint'(in_data);
                lo = w % 524288;
                hi = w / 524288;
                if (in_mode && (w / 268435456) != 0) fmt_m = 1;
                for (int d = 0; d < 2; d++) begin
                    if (in_mode) begin
                        q[d].push_back('{data: 28'(w % 268435456), lane: 1'b0, last: 1'b1});
                    end else begin
                        q[d].push_back('{data: ext19(lo, d == 1), lane: 1'b0, last: 1'b0});
                        q[d].push_back('{data: ext19(hi, d == 1), lane: 1'b1, last: 1'b1});
                    end
                end
            end
        end
    end

    // Beats handed off this cycle were tracked before the pops; remember it per cycle.
    bit had_beat;
    always @(negedge clk) begin
        #3;
        had_beat = (q[0].size() != 0);
    end
    function automatic bit cnt_pending();
        return had_beat;
    endfunction

    always @(negedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = ($urandom_range(3) != 0);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [37:0] d, input logic m);
        int n = 0;
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        forever begin
            #4;
            ok = in_ready[0];
            @(negedge clk);
            if (ok) break;
            n++;
            if (n > 40) begin
                n_chk++;
                $display("FAIL accept_timeout: got no in_ready after %0d cycles, required acceptance", n);
                in_valid = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        logic [37:0] w;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rdy_mode = 1;

        send(38'h3FFFF80005, 1'b0);
        idle(3);
        send(38'h00D592345, 1'b1);
        idle(2);
        send(38'h3FFD592345, 1'b1);
        idle(2);
        send(38'h00D592345, 1'b1);
        send(38'h3FFFF80005, 1'b0);
        idle(3);

        for (int i = 0; i < 8; i++) begin
            w = 38'({$urandom(), $urandom()});
            w[37:28] = '0;
            send(w, 1'b1);
        end
        rdy_mode = 2;
        in_valid = 1'b1;
        in_data  = 38'h0012345678;
        in_mode  = 1'b1;
        repeat (3) @(negedge clk);
        rdy_mode = 1;
        send(38'h0012345678, 1'b1);
        idle(3);

        rdy_mode = 2;
        send(38'h1234580007, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rdy_mode = 1;
        idle(5);

        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            logic m;
            m = 1'($urandom_range(1));
            w = 38'({$urandom(), $urandom()});
            if (m && $urandom_range(3) != 0) w[37:28] = '0;
            send(w, m);
            if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
        end
        rdy_mode = 1;
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end
endmodule

// File: doc/preadd_result_unpacker.md
Name: preadd_result_unpacker

Overview:
- Receive-side counterpart of the combined fixed-point pre-adder.
- Takes the 38-bit packed pre-adder result word and its mode bit, and emits individual results one per beat to the downstream multiplier/accumulator stage.
- Mode 0 (two independent 19-bit sums) produces two beats. Mode 1 (one chained 27-bit sum with carry-out) produces one beat.
- Uses a valid/ready handshake on both sides, a one-entry holding register, a beat FSM, a result counter and a sticky format-error flag.

Parameters:
- SEG_W, 19, width of each pre-adder segment result.
- OUT_W, 28, output result width. Must be ≥ SEG_W+9.
- SIGN_EXT, 0, mode-0 lane extension: 0 = zero-extend, 1 = sign-extend from bit SEG_W-1.
- CNT_W, 16, width of the emitted-result counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  packed word present.
- in_ready  out  1  unpacker can accept a word this cycle.
- in_data  in  2*SEG_W  packed result {seg_hi[37:19], seg_lo[18:0]}.
- in_mode  in  1  0 = dual 19-bit, 1 = single 27-bit.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts beat.
- out_data  out  OUT_W  result value.
- out_lane  out  1  0 = low segment / combined, 1 = high segment.
- out_last  out  1  final beat of the current packed word.
- result_count  out  CNT_W  number of beats accepted downstream.
- fmt_err  out  1  sticky mode-1 format error.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: state EMPTY; out_valid=0; out_data=0; out_lane=0; out_last=0; result_count=0; fmt_err=0; holding register=0. Reset mid-word discards the held word with no further beats.
- States:
  - EMPTY: out_valid=0.
  - BEAT0: out_valid=1, out_lane=0.
  - BEAT1: out_valid=1, out_lane=1.
- in_ready is 1 in EMPTY, or when the current beat is the last beat and out_ready=1 in the same cycle. This gives zero-bubble back-to-back operation. in_ready is combinational from state, held mode and out_ready; there is no path from in_valid.
- Accept occurs when in_valid & in_ready: capture in_data and in_mode, then next state is BEAT0. Output latency is 1 cycle from accept to out_valid.
- BEAT0, mode 1:
  - out_data = zero-extend {seg_hi[8:0], seg_lo[18:0]}. seg_hi[8] is the carry-out, giving bit 27 of the 28-bit sum.
  - out_last=1.
  - On out_ready: accept the next word if offered, otherwise go to EMPTY.
- BEAT0, mode 0:
  - out_data = ext(seg_lo). ext is zero-extension or sign-extension per SIGN_EXT.
  - out_last=0.
  - On out_ready: go to BEAT1.
- BEAT1: out_data = ext(seg_hi); out_last=1. On out_ready, same transition as the mode-1 last beat.
- Stall: while out_valid & !out_ready, out_data, out_lane and out_last hold stable.
- Throughput: mode 1 gives 1 word/cycle; mode 0 gives 1 word per 2 cycles.
- result_count increments by 1 on each out_valid & out_ready and wraps modulo 2^CNT_W.
- fmt_err: set at accept when in_mode=1 and in_data[37:28] != 0 (upper bits of seg_hi must be zero in chained mode). Cleared only by reset. The word is still unpacked, with the upper bits ignored.
- Simultaneous last-beat handoff and new accept: the new word's BEAT0 appears the next cycle, and result_count counts the handed-off beat.
- Mode changes between words are allowed with no penalty.

Decomposition:
- Shared package (preadd_pkg):
  - constants SEG_W=19 and CHAIN_HI_W=9;
  - mode encodings MODE_DUAL=0 and MODE_CHAIN=1;
  - state encoding EMPTY, BEAT0, BEAT1.
- One natural sub-module: preadd_lane_ext, a combinational SEG_W→OUT_W zero/sign extender used for both mode-0 lanes.

Test Plan:
- Mode 0, SIGN_EXT=0, in_data=38'h3FFFF80005, out_ready=1 → beat {28'h0000005, lane0, last0}, then {28'h007FFFF, lane1, last1}; result_count=2.
- Same word with SIGN_EXT=1 → second beat 28'hFFFFFFF; first beat 28'h0000005.
- Mode 1, in_data=38'h00D592345 → single beat 28'hD592345, lane0, last1, 1 cycle after accept; fmt_err stays 0.
- Mode 1, in_data=38'h3FFD592345 → beat 28'hD592345; fmt_err=1 and stays 1 after later valid words.
- Back-to-back mode-1 words with out_ready held 1 → one beat every cycle, in_ready=1 throughout. Then out_ready=0 for 3 cycles → out_data stable, in_ready=0, no beats lost.
- Assert reset during BEAT0 of a mode-0 word → next cycle out_valid=0, result_count=0, and no BEAT1 is emitted.
